// File: rtl/uem_cfg_pkg.sv
// Shared definitions for the UART command controller: frame FSM states and framing constants.
package uem_cfg_pkg;

    typedef enum logic [1:0] {
        S_SYNC,
        S_ADDR,
        S_DATA,
        S_CSUM
    } state_e;

    localparam logic [7:0]  SYNC_BYTE            = 8'hA5;
    localparam int unsigned DEFAULT_TIMEOUT_CLKS = 300;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// Receiver-side byte strobe in, register-bank write port and status out.
interface uart_cmd_ctrl_if #(
    parameter int unsigned ADDR_W = 4
);

    logic              i_Rx_DV;
    logic [7:0]        i_Rx_Byte;
    logic              o_Wr_En;
    logic [ADDR_W-1:0] o_Wr_Addr;
    logic [7:0]        o_Wr_Data;
    logic              o_Busy;
    logic [7:0]        o_Err_Count;

    modport master (
        output i_Rx_DV,
        output i_Rx_Byte,
        input  o_Wr_En,
        input  o_Wr_Addr,
        input  o_Wr_Data,
        input  o_Busy,
        input  o_Err_Count
    );

    modport slave (
        input  i_Rx_DV,
        input  i_Rx_Byte,
        output o_Wr_En,
        output o_Wr_Addr,
        output o_Wr_Data,
        output o_Busy,
        output o_Err_Count
    );

endinterface

// File: rtl/uart_cmd_timeout.sv
// Inter-byte timeout: loadable down-counter, expired once TIMEOUT_CLKS-1 idle clocks have elapsed.
module uart_cmd_timeout #(
    parameter int unsigned TIMEOUT_CLKS = 300
) (
    input  logic i_Clock,
    input  logic i_Rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned      CntW    = $clog2(TIMEOUT_CLKS);
    localparam logic [CntW-1:0] LoadVal = CntW'(TIMEOUT_CLKS - 1);

    // Counts remaining clocks; a freshly loaded value is the "zero elapsed" state.
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt_q <= LoadVal;
        end else if (clear) begin
            cnt_q <= LoadVal;
        end else if (enable && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntW'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/uart_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA/CSUM frames from the UART receiver into single-cycle register writes,
// counting (saturating) every rejected or timed-out frame.
module uart_cmd_ctrl
    import uem_cfg_pkg::*;
#(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
    input logic            i_Clock,
    input logic            i_Rst_n,
    uart_cmd_ctrl_if.slave bus
);

    state_e            state_q;
    logic [7:0]        addr_q;
    logic [7:0]        data_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [7:0]        wr_data_q;
    logic              busy_q;
    logic [7:0]        err_q;

    logic       tmo_expired;
    logic       tmo_clear;
    logic       tmo_enable;
    logic       tmo_fire;
    logic [7:0] csum;
    logic       frame_ok;
    logic [7:0] err_inc;

    always_comb begin
        csum       = addr_q + data_q;
        // Range check uses the full byte so high address bits cannot alias onto a legal register.
        frame_ok   = (bus.i_Rx_Byte == csum) && (32'(addr_q) < NUM_REGS);
        tmo_enable = (state_q != S_SYNC);
        tmo_clear  = (state_q == S_SYNC) || bus.i_Rx_DV;
        tmo_fire   = tmo_enable && !bus.i_Rx_DV && tmo_expired;
        err_inc    = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
    end

    uart_cmd_timeout #(
        .TIMEOUT_CLKS(TIMEOUT_CLKS)
    ) u_timeout (
        .i_Clock(i_Clock),
        .i_Rst_n(i_Rst_n),
        .clear  (tmo_clear),
        .enable (tmo_enable),
        .expired(tmo_expired)
    );

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= S_SYNC;
            addr_q    <= '0;
            data_q    <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            busy_q    <= 1'b0;
            err_q     <= '0;
        end else begin
            wr_en_q <= 1'b0;
            if (tmo_fire) begin
                state_q <= S_SYNC;
                busy_q  <= 1'b0;
                err_q   <= err_inc;
            end else if (bus.i_Rx_DV) begin
                unique case (state_q)
                    S_SYNC: begin
                        if (bus.i_Rx_Byte == SYNC_BYTE) begin
                            state_q <= S_ADDR;
                            busy_q  <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        addr_q  <= bus.i_Rx_Byte;
                        state_q <= S_DATA;
                    end
                    S_DATA: begin
                        data_q  <= bus.i_Rx_Byte;
                        state_q <= S_CSUM;
                    end
                    S_CSUM: begin
                        state_q <= S_SYNC;
                        busy_q  <= 1'b0;
                        if (frame_ok) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= addr_q[ADDR_W-1:0];
                            wr_data_q <= data_q;
                        end else begin
                            err_q <= err_inc;
                        end
                    end
                endcase
            end
        end
    end

    assign bus.o_Wr_En     = wr_en_q;
    assign bus.o_Wr_Addr   = wr_addr_q;
    assign bus.o_Wr_Data   = wr_data_q;
    assign bus.o_Busy      = busy_q;
    assign bus.o_Err_Count = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed frames against uart_cmd_ctrl; expected writes go into a queue checked by a monitor.
module tb_uart_cmd_ctrl;

    typedef struct packed {
        logic [3:0] addr;
        logic [7:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_err  = 0;
    wr_t  exp_q[$];

    uart_cmd_ctrl_if #(.ADDR_W(4)) bus ();

    uart_cmd_ctrl #(
        .NUM_REGS    (16),
        .ADDR_W      (4),
        .TIMEOUT_CLKS(300)
    ) dut (
        .i_Clock(clk),
        .i_Rst_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; leaves the bench at the next negedge with DV low, so
    // consecutive calls give back-to-back bytes with no idle cycle.
    task automatic send_byte(input logic [7:0] b);
        bus.i_Rx_DV   = 1'b1;
        bus.i_Rx_Byte = b;
        @(negedge clk);
        bus.i_Rx_DV   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send_byte(8'hA5);
        send_byte(a);
        send_byte(d);
        send_byte(c);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_drained(input string name);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.o_Wr_En) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         bus.o_Wr_Addr, bus.o_Wr_Data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", bus.o_Wr_Addr, e.addr);
                check("wr_data", bus.o_Wr_Data, e.data);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.i_Rx_DV   = 1'b0;
        bus.i_Rx_Byte = 8'h00;
        #12;
        check("rst_wr_en", bus.o_Wr_En, 0);
        check("rst_wr_addr", bus.o_Wr_Addr, 0);
        check("rst_wr_data", bus.o_Wr_Data, 0);
        check("rst_busy", bus.o_Busy, 0);
        check("rst_err", bus.o_Err_Count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        // Good frame, busy seen mid-frame
        exp_q.push_back('{addr: 4'd3, data: 8'h7E});
        send_byte(8'hA5);
        check("busy_mid_frame", bus.o_Busy, 1);
        send_byte(8'h03);
        send_byte(8'h7E);
        send_byte(8'h81);
        check_drained("good_frame_write");
        check("good_err", bus.o_Err_Count, exp_err);
        check("good_busy_after", bus.o_Busy, 0);
        idle(2);

        // Bad checksum then a good frame
        send_frame(8'h03, 8'h7E, 8'h80);
        exp_err++;
        #1 check("bad_csum_err", bus.o_Err_Count, exp_err);
        exp_q.push_back('{addr: 4'd1, data: 8'h02});
        @(negedge clk);
        send_frame(8'h01, 8'h02, 8'h03);
        check_drained("after_bad_write");

        // Out-of-range addresses, checksums otherwise correct
        @(negedge clk);
        send_frame(8'h10, 8'h00, 8'h10);
        exp_err++;
        #1 check("addr_0x10_err", bus.o_Err_Count, exp_err);
        @(negedge clk);
        send_frame(8'hFF, 8'h01, 8'h00);
        exp_err++;
        #1 check("addr_0xff_err", bus.o_Err_Count, exp_err);
        @(negedge clk);

        // Timeout fires on the 300th edge after the last accepted byte
        send_byte(8'hA5);
        send_byte(8'h05);
        idle(299);
        check("tmo_299_err", bus.o_Err_Count, exp_err);
        check("tmo_299_busy", bus.o_Busy, 1);
        idle(1);
        exp_err++;
        check("tmo_300_err", bus.o_Err_Count, exp_err);
        check("tmo_300_busy", bus.o_Busy, 0);
        idle(2);

        // Byte on edge 299, then a byte exactly on the expiry edge: both accepted
        exp_q.push_back('{addr: 4'd5, data: 8'h10});
        send_byte(8'hA5);
        send_byte(8'h05);
        idle(298);
        send_byte(8'h10);
        idle(299);
        send_byte(8'h15);
        check_drained("late_bytes_write");
        check("late_bytes_err", bus.o_Err_Count, exp_err);
        idle(3);
        check("wr_addr_held", bus.o_Wr_Addr, 5);
        check("wr_data_held", bus.o_Wr_Data, 8'h10);

        // Noise, A5 inside a frame, back-to-back frames
        exp_q.push_back('{addr: 4'd2, data: 8'hA5});
        exp_q.push_back('{addr: 4'd0, data: 8'h00});
        send_byte(8'h00);
        send_byte(8'hFF);
        send_frame(8'h02, 8'hA5, 8'hA7);
        send_frame(8'h00, 8'h00, 8'h00);
        check_drained("b2b_writes");
        check("b2b_err", bus.o_Err_Count, exp_err);
        check("b2b_busy", bus.o_Busy, 0);
        idle(2);

        // Asynchronous reset mid-frame
        send_byte(8'hA5);
        send_byte(8'h04);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", bus.o_Busy, 0);
        check("midrst_err", bus.o_Err_Count, 0);
        check("midrst_wr_addr", bus.o_Wr_Addr, 0);
        check("midrst_wr_data", bus.o_Wr_Data, 0);
        exp_err = 0;
        @(negedge clk);
        rst_n = 1'b1;
        send_byte(8'h06);
        send_byte(8'h0A);
        idle(1);
        check("postrst_busy", bus.o_Busy, 0);
        check("postrst_err", bus.o_Err_Count, exp_err);
        check_drained("postrst_no_write");

        // Saturation
        @(negedge clk);
        for (int i = 0; i < 255; i++) send_frame(8'h01, 8'h01, 8'h00);
        #1 check("sat_255", bus.o_Err_Count, 255);
        @(negedge clk);
        for (int i = 0; i < 5; i++) send_frame(8'h01, 8'h01, 8'h00);
        #1 check("sat_hold", bus.o_Err_Count, 255);
        check_drained("sat_no_write");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_ctrl.md
# uart_cmd_ctrl

Frame-level controller that sits directly behind the UART receiver and turns its byte stream into register-write commands. It consumes the receiver's one-cycle valid strobe and byte. It parses fixed 4-byte frames: sync, address, data, checksum. For each good frame it issues a single write strobe to the design's configuration register bank. Bad checksums, out-of-range addresses and inter-byte timeouts are discarded and counted.

## Interface
Parameters:
- NUM_REGS, 16: number of writable registers; legal addresses are 0..NUM_REGS-1.
- ADDR_W, 4: width of o_Wr_Addr; must satisfy 2^ADDR_W >= NUM_REGS.
- TIMEOUT_CLKS, 300: maximum clocks allowed between consecutive bytes inside a frame. The default is 3 byte times at CLKS_PER_BIT=10. Must be >= 2.

Ports:
- i_Clock, input, 1: the single clock. The block, the UART receiver and the register bank all run on it.
- i_Rst_n, input, 1: reset, asynchronous and active-low.
- i_Rx_DV, input, 1: byte-valid strobe from the receiver, one cycle wide.
- i_Rx_Byte, input, 8: received byte. Sampled only when i_Rx_DV=1.
- o_Wr_En, output, 1: one-cycle write strobe to the register bank.
- o_Wr_Addr, output, ADDR_W: write address. Valid while o_Wr_En=1 and held until the next write.
- o_Wr_Data, output, 8: write data. Valid while o_Wr_En=1 and held until the next write.
- o_Busy, output, 1: high while a frame is partially received, i.e. in any state other than S_SYNC.
- o_Err_Count, output, 8: count of rejected frames. Saturates at 255.

## Operation
- Frame format: 0xA5 (SYNC), ADDR, DATA, CSUM, where CSUM = (ADDR + DATA) mod 256.
- States and transitions (every transition requires i_Rx_DV=1 unless noted otherwise):
  - S_SYNC: a byte equal to 0xA5 moves to S_ADDR. Any other byte is ignored silently and does not count as an error.
  - S_ADDR: latch the byte into addr_q and move to S_DATA.
  - S_DATA: latch the byte into data_q and move to S_CSUM.
  - S_CSUM: return to S_SYNC. Then:
    - If the checksum matches and addr_q < NUM_REGS, perform the write.
    - Otherwise, increment the error count.
- Write action:
  - The block asserts o_Wr_En for exactly one cycle.
  - o_Wr_Addr is loaded with addr_q[ADDR_W-1:0] and o_Wr_Data with data_q.
- Checksum arithmetic is 8-bit and wraps. The full 8-bit addr_q is range-checked before truncation, so an address of 0x10 with NUM_REGS=16 is rejected.
- Timeout:
  - A counter runs in every state except S_SYNC. It is cleared by each accepted byte and is held at 0 in S_SYNC.
  - When it reaches TIMEOUT_CLKS-1 with no i_Rx_DV, the block returns to S_SYNC and increments the error count.
  - If i_Rx_DV arrives on the same cycle as expiry, the byte wins and there is no timeout.
- Resync: 0xA5 received in S_ADDR, S_DATA or S_CSUM is treated as ordinary frame content. There is no mid-frame resync.
- o_Err_Count saturates: an increment at 255 leaves it at 255. At most one increment occurs per cycle.

## Timing
- Reset values: o_Wr_En=0, o_Wr_Addr=0, o_Wr_Data=0, o_Busy=0, o_Err_Count=0, state=S_SYNC, timeout counter=0.
- Reset is asynchronous: asserting i_Rst_n mid-frame aborts the frame immediately, with no write and no error count.
- Write latency: o_Wr_En is high in the cycle after the clock edge that samples i_Rx_DV with the CSUM byte.
- The error count updates on the same edge the write would have occurred.
- o_Busy is registered. It rises in the cycle after the SYNC byte is accepted and falls in the cycle after the CSUM byte or the timeout.
- Back-to-back frames need no gap. The SYNC byte of the next frame may arrive on the cycle immediately after the CSUM byte.
- The timeout fires exactly TIMEOUT_CLKS cycles after the last accepted byte.

## Structure
- The shared package uem_cfg_pkg holds:
  - the state enum (S_SYNC, S_ADDR, S_DATA, S_CSUM, 2-bit);
  - the constant SYNC_BYTE = 8'hA5;
  - the default TIMEOUT_CLKS.
- Sub-module uart_cmd_timeout: a loadable down-counter with inputs clear and enable and output expired, width $clog2(TIMEOUT_CLKS). It is instantiated once.
- The FSM, latches, checksum compare and error counter stay in uart_cmd_ctrl.

## Test plan
- Good frame: bytes A5 03 7E 81 -> one o_Wr_En pulse with addr=3, data=0x7E. o_Err_Count=0. o_Busy low afterwards.
- Bad checksum: bytes A5 03 7E 80 -> no write, o_Err_Count=1. A following good frame A5 01 02 03 then writes addr=1, data=2.
- Out-of-range address: A5 10 00 10 with NUM_REGS=16 -> no write, o_Err_Count increments. Also A5 FF 01 00 -> rejected.
- Timeout: A5 05, then silence for 300 clocks -> return to S_SYNC and o_Err_Count+1 at exactly cycle 300. Separately, a byte arriving on cycle 299 is accepted with no error.
- Noise and back-to-back: 00 FF A5 02 A5 A7, then A5 00 00 00 with zero gaps -> leading bytes ignored, writes (2, 0xA5) and (0, 0x00), no errors.
- Reset and saturation: assert i_Rst_n low after A5 04 -> all outputs at reset values, no write. Then 260 bad frames -> o_Err_Count holds at 255.
